mul8_seq_ctrl: RTL and testbench

MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

---
 rtl/mul8_seq_ctrl_pkg.sv | 25 ++
 rtl/mul8_seq_ctrl_if.sv | 25 ++
 rtl/mul8_seq_ctrl_array_multiplier.sv | 18 +
 rtl/mul8_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mul8_seq_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mul8_seq_ctrl_pkg.sv
// rtl/mul8_seq_ctrl_pkg.sv - shared types, widths and step decode for the sequential 8x8 multiplier
package mul8_seq_ctrl_pkg;

  localparam int OPW   = 8;
  localparam int PW    = 16;
  localparam int STEPW = 2;
  localparam int NIBW  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial-product weight for each step: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [3:0] step_shift(input logic [STEPW-1:0] step);
    case (step)
      2'd0:    step_shift = 4'd0;
      2'd1:    step_shift = 4'd4;
      2'd2:    step_shift = 4'd4;
      default: step_shift = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// rtl/mul8_seq_ctrl_if.sv - operand/result handshake bundle for the sequential multiplier
interface mul8_seq_ctrl_if;
  import mul8_seq_ctrl_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  product;

  // Requester / consumer side.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/mul8_seq_ctrl_array_multiplier.sv
// rtl/mul8_seq_ctrl_array_multiplier.sv - 4x4 unsigned combinational array multiplier
module array_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Sum one AND-gated row of a per bit of b, each row weighted by its bit position.
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        p = p + ({4'b0000, a} << i);
      end
    end
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiplier time-sharing one 4x4 core over four cycles
module mul8_seq_ctrl
  import mul8_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mul8_seq_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [STEPW-1:0] step_q, step_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [NIBW-1:0]  a_nib;
  logic [NIBW-1:0]  b_nib;
  logic [7:0]       pp;
  logic [PW-1:0]    pp_shifted;

  // Nibble select comes from step alone: bit0 picks the a half, bit1 picks the b half.
  assign a_nib = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[1] ? b_q[7:4] : b_q[3:0];

  array_multiplier u_core (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  assign pp_shifted = {8'h00, pp} << step_shift(step_q);

  // Next-state and datapath update for IDLE -> CALC x4 -> DONE -> IDLE.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          acc_d      = '0;
          step_d     = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + STEPW'(1);
        if (step_q == STEPW'(3)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered handshake outputs; in_ready_q rests at 1 so IDLE is ready right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  assign bus.in_ready  = in_ready_q & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - scoreboard bench for mul8_seq_ctrl
module tb_mul8_seq_ctrl;

  logic clk;
  logic rst_n;

  mul8_seq_ctrl_if bus ();

  mul8_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    int          acc_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  bit          busy = 0;
  int          acc_edge = 0;
  bit          prev_ov = 0;
  logic [15:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: protocol timing and golden products, pushed at each accept.
  always @(negedge clk) begin
    bit ov_exp;
    if (!rst_n) begin
      busy = 0;
      exp_q.delete();
    end else begin
      ov_exp = busy && (cyc >= acc_edge + 4);
      chk("in_ready", 32'(bus.in_ready), 32'(!busy));
      chk("out_valid", 32'(bus.out_valid), 32'(ov_exp));
      if (ov_exp && bus.out_ready) begin
        busy = 0;
      end else if (!busy && bus.in_valid) begin
        exp_t e;
        busy     = 1;
        acc_edge = cyc + 1;
        e.prod     = 16'(bus.a) * 16'(bus.b);
        e.acc_edge = acc_edge;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pops on each out_valid rise, checks product, latency and hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", 32'(bus.product), 32'(e.prod));
          chk("latency", 32'(cyc - e.acc_edge), 32'd4);
          held = bus.product;
        end
      end else if (bus.out_valid && prev_ov) begin
        chk("product_hold", 32'(bus.product), 32'(held));
      end
      prev_ov = bus.out_valid;
    end
  end

  // Present one operation from a post-edge slot and run it through the result handshake.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                        input bit rand_ready, input bit junk, input int hold);
    int n;
    int seen;
    bit done;
    bus.in_valid  = 1'b1;
    bus.a         = ai;
    bus.b         = bi;
    bus.out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      return;
    end
    n    = 0;
    seen = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      if (junk) begin
        if (n == 0) begin
          bus.in_valid = 1'b1;
          bus.a        = 8'h0F;
          bus.b        = 8'h0F;
        end else begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.a        = 8'($urandom);
          bus.b        = 8'($urandom);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : (seen >= hold);
      @(negedge clk);
      if (bus.out_valid) seen++;
      if (bus.out_valid && bus.out_ready) done = 1;
      n++;
    end
    if (!done) chk("result_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    run_op(8'h12, 8'h34, 0, 0, 0);
    run_op(8'hFF, 8'hFF, 0, 0, 0);
    run_op(8'h00, 8'hA5, 0, 0, 0);
    run_op(8'h12, 8'h34, 0, 0, 5);
    run_op(8'h12, 8'h34, 0, 1, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Abort mid-operation once step has reached 2.
    bus.in_valid  = 1'b1;
    bus.a         = 8'h12;
    bus.b         = 8'h34;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_op(8'h10, 8'h10, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      run_op(8'($urandom), 8'($urandom), 1, 1, 0);
    end

    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
